// File: rtl/shift_cmd_player.sv
// Command sequencer driving a 2-bit select / DW-bit data shift register: replays stored
// vectors, one per step, and captures the shifter output. Optional golden model: RESULT_CHECK_EN.
module shift_cmd_player #(
   parameter int DW          = 8,
   parameter int NUM_VECS    = 8,
   parameter int HOLD_CYCLES = 2,
   localparam int AW         = $clog2(NUM_VECS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW+1:0] wr_data,
   input  logic [AW:0]   num_vecs,
   input  logic          start,
   output logic [1:0]    sel_o,
   output logic [DW-1:0] data_o,
   input  logic [DW-1:0] shr_q,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic          done,
   output logic [7:0]    mismatch_cnt,
   output logic [AW:0]   first_fail
);

   localparam int          HW        = $clog2(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [AW:0]   MAX_N     = (AW + 1)'(NUM_VECS);

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] idx, idx_nx;
   logic [HW-1:0] hold_cnt, hold_nx;
   logic [AW:0]   n_play, n_play_nx;
   logic          capture;
   logic          run_clr;

   logic [DW+1:0] vec  [NUM_VECS];
   logic [DW-1:0] resp [NUM_VECS];

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values; blocking here would create ordering races.
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         hold_cnt <= '0;
         n_play   <= '0;
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         hold_cnt <= hold_nx;
         n_play   <= n_play_nx;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a value unassigned (no latches).
      state_nx  = state;
      idx_nx    = idx;
      hold_nx   = hold_cnt;
      n_play_nx = n_play;
      capture   = 1'b0;
      run_clr   = 1'b0;
      sel_o     = 2'b00;
      data_o    = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               run_clr   = 1'b1;
               n_play_nx = (num_vecs > MAX_N) ? MAX_N : num_vecs;
               idx_nx    = '0;
               hold_nx   = '0;
               state_nx  = (num_vecs == '0) ? DONE : PLAY;
            end
         end
         PLAY: begin
            busy   = 1'b1;
            data_o = vec[idx][DW-1:0];
            // Only the command cycle carries a non-hold select to the shifter.
            if (hold_cnt == '0) sel_o = vec[idx][DW+1:DW];
            if (hold_cnt == HOLD_LAST) begin
               capture = 1'b1;
               hold_nx = '0;
               if ((AW + 1)'(idx) == n_play - (AW + 1)'(1)) state_nx = DONE;
               else                                        idx_nx   = idx + AW'(1);
            end else begin
               hold_nx = hold_cnt + HW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: the vector and response arrays are deliberately left out of reset so
   // they map onto plain storage and survive an aborted run.
   always_ff @(posedge clk) begin
      if (wr_en && state != PLAY) vec[wr_addr] <= wr_data;
      if (capture)                resp[idx]    <= shr_q;
   end

   assign rd_data = resp[rd_addr];

`ifdef RESULT_CHECK_EN
   logic [DW-1:0] model;

   always_ff @(posedge clk) begin
      if (reset) begin
         model        <= '0;
         mismatch_cnt <= '0;
         first_fail   <= '1;
      end else if (run_clr) begin
         model        <= '0;
         mismatch_cnt <= '0;
         first_fail   <= '1;
      end else begin
         case (sel_o)
            2'b01:   model <= {model[DW-2:0], 1'b0};
            2'b10:   model <= {1'b0, model[DW-1:1]};
            2'b11:   model <= data_o;
            default: model <= model;
         endcase
         if (capture && shr_q != model) begin
            if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
            if (first_fail == '1)      first_fail   <= {1'b0, idx};
         end
      end
   end
`else
   assign mismatch_cnt = '0;
   assign first_fail   = '1;
`endif

endmodule

// File: doc/shift_cmd_player.md
Name: shift_cmd_player

Overview:
- Register-array command sequencer: the driving end of the `shiftregister` 2-bit select / 8-bit data interface.
- Stores up to NUM_VECS command vectors {sel[1:0], data[DW-1:0]} written over a host port.
- On `start`, replays the vectors to a shift register one step at a time, then captures the shifter's parallel output into a response array.
- Sits beside the shifter as an on-chip stimulus/response engine, replacing the bench-only vector playback.

Parameters:
- DW, 8, data width of the shifter interface.
- NUM_VECS, 8, depth of the vector and response arrays; a power of two, at least 2.
- AW, $clog2(NUM_VECS), address width (localparam, derived).
- HOLD_CYCLES, 2, cycles per step: 1 command cycle plus HOLD_CYCLES-1 settle cycles. Must be at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  vector write strobe.
- wr_addr  in  AW  vector write index.
- wr_data  in  DW+2  vector to write, {sel, data}.
- num_vecs  in  AW+1  number of vectors to play, 0..NUM_VECS.
- start  in  1  single-cycle start pulse.
- sel_o  out  2  to shifter select. Encoding: 00 hold, 01 shift left 1 with zero fill, 10 shift right 1 with zero fill, 11 parallel load.
- data_o  out  DW  to shifter parallel data.
- shr_q  in  DW  shifter parallel output.
- rd_addr  in  AW  response read index.
- rd_data  out  DW  response array entry, combinational read.
- busy  out  1  high in PLAY.
- done  out  1  high in DONE.
- mismatch_cnt  out  8  see Optional Feature.
- first_fail  out  AW+1  see Optional Feature.

Behaviour:
- Reset:
  - state=IDLE; sel_o=00, data_o=0, busy=0, done=0, idx=0, hold_cnt=0, mismatch_cnt=0, first_fail=all ones.
  - Vector and response arrays are not cleared.
- States:
  - IDLE: outputs 00/0.
  - On start: if num_vecs==0, go to DONE next cycle; otherwise idx<=0, hold_cnt<=0, go to PLAY.
  - PLAY, hold_cnt==0: sel_o=vec[idx].sel, data_o=vec[idx].data. This is the command cycle; exactly one shifter edge sees the command.
  - PLAY, hold_cnt 1..HOLD_CYCLES-1: sel_o=00, data_o is held at vec[idx].data.
  - PLAY, hold_cnt==HOLD_CYCLES-1: resp[idx]<=shr_q; hold_cnt<=0. If idx==num_vecs-1, go to DONE; otherwise idx<=idx+1.
  - DONE: outputs 00/0, done=1 until the next start, which behaves as start from IDLE.
- Latency:
  - The first command appears on sel_o/data_o one cycle after start is sampled.
  - Total run is num_vecs*HOLD_CYCLES cycles in PLAY.
  - done rises the cycle after the last capture.
- Writes: wr_en is honoured only in IDLE/DONE and ignored in PLAY. wr_addr beyond NUM_VECS-1 cannot occur (power-of-two depth).
- start while in PLAY is ignored.
- num_vecs greater than NUM_VECS is clamped to NUM_VECS when start is sampled.
- Simultaneous wr_en and start in IDLE: the write completes, and PLAY reads the new value because the first read occurs one cycle later.
- reset in the middle of PLAY:
  - Aborts to IDLE with sel_o=00 on the next edge.
  - Partially filled responses are retained.
  - done stays 0.
- rd_data reflects a write to the same entry one cycle after the write.

Optional Feature:
- Macro: RESULT_CHECK_EN.
- When defined, the block contains an internal golden shifter model:
  - The model is cleared to 0 on start.
  - It applies the same sel/data on each command cycle and holds otherwise.
  - On each capture, shr_q is compared against the model. On mismatch, mismatch_cnt increments, saturating at 255, and first_fail latches idx on the first failure of the run.
  - Both counters clear on start.
- When undefined, the model is not built; mismatch_cnt is tied to 0 and first_fail to all ones. The port list is unchanged.

Test Plan:
- Vectors 11/0x33, 01/0x33, 10/0x33, 00/0x33, 10/0x33; num_vecs=5, HOLD_CYCLES=2, real shifter attached.
  - Required responses: 0x33, 0x66, 0x33, 0x33, 0x19. done asserts 11 cycles after start; busy is high for exactly 10 cycles.
- num_vecs=0 with start -> done=1 one cycle later; sel_o stays 00 and resp is unchanged.
- wr_en pulsed during PLAY at index 0 with 11/0xFF -> vec[0] unchanged; a rerun reproduces the first test's results.
- reset asserted on the 3rd command cycle -> next cycle sel_o=00, busy=0, done=0; resp[0..1] retain 0x33, 0x66.
- RESULT_CHECK_EN defined, shifter replaced by a stub that returns shr_q=0x00 on step 2 -> mismatch_cnt=1, first_fail=1.
- RESULT_CHECK_EN undefined, any run -> mismatch_cnt=0, first_fail=all ones.
